phi_copy_sequencer: RTL and testbench

- Hardware scheduler for the phi-elimination copy datapath.
- Accepts one predecessor block's parallel copy set (dst <- src register pairs) and emits it as a legal sequential move stream on a valid/ready port.
- Orders moves so that no source is overwritten before it is read. Copy cycles are broken through a reserved temporary register.
- Sits between the phi-lowering front end and the move-insertion / register-file write stage.

---
 rtl/phi_copy_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_phi_copy_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phi_copy_sequencer.sv
// phi_copy_sequencer
// Collects one predecessor block's parallel copy set (dst <- src pairs) and
// replays it as a sequential move stream. A move is issued only when no other
// pending copy still reads its destination. When only cycles remain, the cycle
// is broken by parking one destination in the reserved temporary register.

module phi_copy_sequencer #(
    parameter int REG_W      = 5,
    parameter int MAX_COPIES = 8,
    parameter int TEMP_REG   = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [REG_W-1:0] cfg_dst,
    input  logic [REG_W-1:0] cfg_src,
    input  logic             cfg_last,
    output logic             mv_valid,
    input  logic             mv_ready,
    output logic [REG_W-1:0] mv_dst,
    output logic [REG_W-1:0] mv_src,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CNT_W = $clog2(MAX_COPIES + 1);
    localparam int IDX_W = (MAX_COPIES > 1) ? $clog2(MAX_COPIES) : 1;
    localparam logic [REG_W-1:0] TEMP = REG_W'(TEMP_REG);

    typedef enum logic [1:0] {
        S_LOAD,
        S_SCAN,
        S_EMIT,
        S_DONE
    } state_t;

    typedef enum logic {
        K_NORMAL,
        K_BREAK
    } kind_t;

    // Control / output registers
    state_t             state_q;
    kind_t              kind_q;
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   count_q;
    logic               cfg_ready_q;
    logic               mv_valid_q;
    logic [REG_W-1:0]   mv_dst_q;
    logic [REG_W-1:0]   mv_src_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    // Flattened views of the copy table
    logic [REG_W-1:0]      dst_vec [MAX_COPIES];
    logic [REG_W-1:0]      src_vec [MAX_COPIES];
    logic [MAX_COPIES-1:0] pend_vec;
    logic [MAX_COPIES-1:0] ready_vec;
    logic [MAX_COPIES-1:0] dst_hit_vec;
    logic [MAX_COPIES-1:0] break_hit_vec;

    // Decoded strobes
    logic cfg_fire;
    logic is_noop;
    logic uses_temp;
    logic dup_dst;
    logic table_full;
    logic store_en;
    logic beat_err;
    logic mv_fire;
    logic table_clr;

    logic             ready_found;
    logic [IDX_W-1:0] ready_idx;
    logic [IDX_W-1:0] pend_idx;

    assign cfg_ready = cfg_ready_q;
    assign mv_valid  = mv_valid_q;
    assign mv_dst    = mv_dst_q;
    assign mv_src    = mv_src_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

    // Classify the incoming beat and the outgoing handshake
    always_comb begin
        cfg_fire   = (state_q == S_LOAD) && cfg_valid && cfg_ready_q;
        is_noop    = (cfg_dst == cfg_src);
        uses_temp  = (cfg_dst == TEMP) || (cfg_src == TEMP);
        dup_dst    = |dst_hit_vec;
        table_full = (count_q == CNT_W'(MAX_COPIES));
        store_en   = cfg_fire && !is_noop && !uses_temp && !dup_dst && !table_full;
        beat_err   = cfg_fire && !is_noop && (uses_temp || dup_dst || table_full);
        mv_fire    = (state_q == S_EMIT) && mv_valid_q && mv_ready;
        table_clr  = (state_q == S_DONE);
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < MAX_COPIES; gi++) begin : g_entry
            logic [REG_W-1:0]      dst_q;
            logic [REG_W-1:0]      src_q;
            logic                  pend_q;
            logic [MAX_COPIES-1:0] blk;

            assign dst_vec[gi]  = dst_q;
            assign src_vec[gi]  = src_q;
            assign pend_vec[gi] = pend_q;

            // An entry is blocked while any other pending copy still reads its destination
            for (gj = 0; gj < MAX_COPIES; gj++) begin : g_blk
                if (gi == gj) begin : g_self
                    assign blk[gj] = 1'b0;
                end else begin : g_other
                    assign blk[gj] = pend_vec[gj] && (src_vec[gj] == dst_q);
                end
            end

            assign ready_vec[gi]     = pend_q && !(|blk);
            assign dst_hit_vec[gi]   = pend_q && (dst_q == cfg_dst);
            assign break_hit_vec[gi] = pend_q && (src_q == dst_vec[idx_q]);

            // Per-entry storage: load on accept, retire on a normal move, redirect reads on a break
            always_ff @(posedge clk) begin
                if (rst) begin
                    dst_q  <= '0;
                    src_q  <= '0;
                    pend_q <= 1'b0;
                end else if (table_clr) begin
                    pend_q <= 1'b0;
                end else begin
                    if (store_en && (count_q == CNT_W'(gi))) begin
                        dst_q  <= cfg_dst;
                        src_q  <= cfg_src;
                        pend_q <= 1'b1;
                    end
                    if (mv_fire && (kind_q == K_NORMAL) && (idx_q == IDX_W'(gi))) begin
                        pend_q <= 1'b0;
                    end
                    if (mv_fire && (kind_q == K_BREAK) && break_hit_vec[gi]) begin
                        src_q <= TEMP;
                    end
                end
            end
        end
    endgenerate

    // Lowest-index ready entry and lowest-index pending entry
    always_comb begin
        ready_found = 1'b0;
        ready_idx   = '0;
        pend_idx    = '0;
        for (int i = MAX_COPIES - 1; i >= 0; i--) begin
            if (ready_vec[i]) begin
                ready_found = 1'b1;
                ready_idx   = IDX_W'(i);
            end
            if (pend_vec[i]) begin
                pend_idx = IDX_W'(i);
            end
        end
    end

    // Sequencer FSM with registered handshake and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOAD;
            kind_q      <= K_NORMAL;
            idx_q       <= '0;
            count_q     <= '0;
            cfg_ready_q <= 1'b1;
            mv_valid_q  <= 1'b0;
            mv_dst_q    <= '0;
            mv_src_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (beat_err) begin
                err_q <= 1'b1;
            end
            case (state_q)
                S_LOAD: begin
                    if (store_en) begin
                        count_q <= count_q + CNT_W'(1);
                    end
                    if (cfg_fire && cfg_last) begin
                        state_q     <= S_SCAN;
                        cfg_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (pend_vec == '0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (ready_found) begin
                        mv_dst_q   <= dst_vec[ready_idx];
                        mv_src_q   <= src_vec[ready_idx];
                        kind_q     <= K_NORMAL;
                        idx_q      <= ready_idx;
                        mv_valid_q <= 1'b1;
                        state_q    <= S_EMIT;
                    end else begin
                        // Only cycles remain: save one destination before it is overwritten
                        mv_dst_q   <= TEMP;
                        mv_src_q   <= dst_vec[pend_idx];
                        kind_q     <= K_BREAK;
                        idx_q      <= pend_idx;
                        mv_valid_q <= 1'b1;
                        state_q    <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (mv_fire) begin
                        mv_valid_q <= 1'b0;
                        state_q    <= S_SCAN;
                    end
                end
                S_DONE: begin
                    count_q     <= '0;
                    cfg_ready_q <= 1'b1;
                    state_q     <= S_LOAD;
                end
                default: begin
                    state_q <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phi_copy_sequencer.sv
// Directed bench for phi_copy_sequencer: loads copy sets, collects the move
// stream and compares it with hand-derived move orders.

module tb_phi_copy_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [4:0] cfg_dst;
    logic [4:0] cfg_src;
    logic       cfg_last;
    logic       mv_valid;
    logic       mv_ready;
    logic [4:0] mv_dst;
    logic [4:0] mv_src;
    logic       busy;
    logic       done;
    logic       err;

    phi_copy_sequencer #(
        .REG_W(5),
        .MAX_COPIES(8),
        .TEMP_REG(31)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_dst(cfg_dst),
        .cfg_src(cfg_src),
        .cfg_last(cfg_last),
        .mv_valid(mv_valid),
        .mv_ready(mv_ready),
        .mv_dst(mv_dst),
        .mv_src(mv_src),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] pr(input int d, input int s);
        logic [4:0] dd;
        logic [4:0] ss;
        dd = 5'(d);
        ss = 5'(s);
        return {dd, ss};
    endfunction

    // Move monitor: records handshakes, done pulses and checks stall stability
    logic [9:0] moves[$];
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         stall_cycles = 0;
    bit         stall_seen = 0;
    logic [4:0] held_dst;
    logic [4:0] held_src;

    always @(negedge clk) begin
        if (!rst) begin
            if (stall_seen) begin
                check_val("stall_valid", {31'd0, mv_valid}, 32'd1);
                check_val("stall_dst", {27'd0, mv_dst}, {27'd0, held_dst});
                check_val("stall_src", {27'd0, mv_src}, {27'd0, held_src});
            end
            stall_seen = mv_valid && !mv_ready;
            if (stall_seen) begin
                held_dst = mv_dst;
                held_src = mv_src;
                stall_cycles++;
            end
            if (mv_valid && mv_ready) begin
                moves.push_back({mv_dst, mv_src});
                $display("move r%0d <- r%0d (cycle %0d)", mv_dst, mv_src, cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end else begin
            stall_seen = 0;
        end
    end

    // Consumer: always ready, or holds ready low stall_len cycles per move
    bit stall_mode = 0;
    int stall_len  = 5;
    int wait_cnt   = 0;
    initial begin
        mv_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!stall_mode) begin
                mv_ready = 1'b1;
            end else if (mv_valid) begin
                if (wait_cnt < stall_len) begin
                    mv_ready = 1'b0;
                    wait_cnt++;
                end else begin
                    mv_ready = 1'b1;
                end
            end else begin
                mv_ready = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    int hs_cyc;
    logic [9:0] cfg_q[$];
    logic [9:0] exp_q[$];

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One configuration beat; called 1 time unit after a rising edge
    task automatic send(input logic [4:0] d, input logic [4:0] s, input bit last);
        int n;
        cfg_valid = 1'b1;
        cfg_dst   = d;
        cfg_src   = s;
        cfg_last  = last;
        @(negedge clk);
        n = 0;
        while (!cfg_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cfg_ready) check_val("cfg_ready_wait", {31'd0, cfg_ready}, 32'd1);
        hs_cyc = cyc;
        $display("cfg r%0d <- r%0d last=%0d (cycle %0d)", d, s, last, cyc);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic run_set(input string tag);
        int n;
        moves.delete();
        done_cnt     = 0;
        stall_cycles = 0;
        foreach (cfg_q[i]) send(cfg_q[i][9:5], cfg_q[i][4:0], i == cfg_q.size() - 1);
        check_val({tag, "_busy"}, {31'd0, busy}, 32'd1);
        check_val({tag, "_cfg_ready_low"}, {31'd0, cfg_ready}, 32'd0);
        n = 0;
        while (done_cnt == 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_done_seen"}, done_cnt, 32'd1);
        repeat (2) @(negedge clk);
        check_val({tag, "_done_once"}, done_cnt, 32'd1);
        check_val({tag, "_idle_ready"}, {31'd0, cfg_ready}, 32'd1);
        check_val({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        check_val({tag, "_nmoves"}, moves.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < moves.size()) check_val($sformatf("%s_move%0d", tag, i), {22'd0, moves[i]}, {22'd0, exp_q[i]});
        end
        $display("set %s: %0d moves, done at cycle %0d", tag, moves.size(), done_cyc);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_dst   = '0;
        cfg_src   = '0;
        cfg_last  = 1'b0;
        @(posedge clk);
        #1;
        apply_reset();

        check_val("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        check_val("rst_mv_valid", {31'd0, mv_valid}, 32'd0);
        check_val("rst_mv_dst", {27'd0, mv_dst}, 32'd0);
        check_val("rst_mv_src", {27'd0, mv_src}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_err", {31'd0, err}, 32'd0);

        // 1: single no-op beat
        cfg_q = '{pr(3, 3)};
        exp_q = {};
        run_set("noop");
        check_val("noop_done_delay", done_cyc - hs_cyc, 32'd2);
        check_val("noop_err", {31'd0, err}, 32'd0);

        // 2: chain
        cfg_q = '{pr(1, 2), pr(2, 3)};
        exp_q = '{pr(1, 2), pr(2, 3)};
        run_set("chain");

        // 3: swap
        cfg_q = '{pr(1, 2), pr(2, 1)};
        exp_q = '{pr(31, 1), pr(1, 2), pr(2, 31)};
        run_set("swap");

        // 4: rotation plus fan-out
        cfg_q = '{pr(1, 2), pr(2, 3), pr(3, 1), pr(4, 1)};
        exp_q = '{pr(4, 1), pr(31, 1), pr(1, 2), pr(2, 3), pr(3, 31)};
        run_set("rot");
        check_val("rot_err", {31'd0, err}, 32'd0);

        // 5: swap under backpressure
        stall_len  = 5;
        stall_mode = 1;
        cfg_q = '{pr(1, 2), pr(2, 1)};
        exp_q = '{pr(31, 1), pr(1, 2), pr(2, 31)};
        run_set("bp");
        check_val("bp_stall_cycles", stall_cycles, 32'd15);
        stall_mode = 0;

        // 6a: overflow, ninth pair dropped
        cfg_q = {};
        exp_q = {};
        for (int i = 1; i <= 9; i++) begin
            cfg_q.push_back(pr(i, i + 9));
            if (i <= 8) exp_q.push_back(pr(i, i + 9));
        end
        run_set("ovf");
        check_val("ovf_err", {31'd0, err}, 32'd1);
        apply_reset();
        check_val("ovf_err_cleared", {31'd0, err}, 32'd0);

        // 6b: pair touching the temporary register is dropped
        cfg_q = '{pr(5, 31), pr(6, 7)};
        exp_q = '{pr(6, 7)};
        run_set("temp");
        check_val("temp_err", {31'd0, err}, 32'd1);

        // 6c: reset while a move is offered
        stall_len  = 1000;
        stall_mode = 1;
        send(5'd1, 5'd2, 1'b1);
        n = 0;
        while (!mv_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("rstemit_valid_before", {31'd0, mv_valid}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("rstemit_mv_valid", {31'd0, mv_valid}, 32'd0);
        check_val("rstemit_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        check_val("rstemit_err", {31'd0, err}, 32'd0);
        check_val("rstemit_busy", {31'd0, busy}, 32'd0);
        check_val("rstemit_mv_dst", {27'd0, mv_dst}, 32'd0);
        rst = 1'b0;
        stall_mode = 0;

        // Table must be empty after the reset: only the new set is emitted
        cfg_q = '{pr(8, 9)};
        exp_q = '{pr(8, 9)};
        run_set("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
